// File: rtl/tlp_tx_arbiter.sv
// Packet-level TX arbiter: merges NUM_SRC 64-bit TLP source streams onto one
// TX stream. A grant is held from SOP through EOP so packets never interleave.
// The output is a two-entry skid stage (output register plus skid register).
// Source readies depend only on registered state and source inputs, never on
// txReady_in.
module tlp_tx_arbiter #(
  parameter int NUM_SRC     = 3,
  parameter bit STRICT_SRC0 = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [NUM_SRC*64-1:0] srcData_in,
  input  logic [NUM_SRC-1:0]    srcValid_in,
  input  logic [NUM_SRC-1:0]    srcSOP_in,
  input  logic [NUM_SRC-1:0]    srcEOP_in,
  output logic [NUM_SRC-1:0]    srcReady_out,
  output logic [63:0]           txData_out,
  output logic                  txValid_out,
  output logic                  txSOP_out,
  output logic                  txEOP_out,
  input  logic                  txReady_in,
  output logic [NUM_SRC-1:0]    grant_out,
  output logic [NUM_SRC-1:0]    frameErr_out
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      pick;
  logic               first_q, first_d;
  logic               found;
  logic [NUM_SRC-1:0] err_q, err_d;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] eligible;
  logic [63:0]        src_data [NUM_SRC];

  logic               accept;
  logic [63:0]        beat_data;
  logic               beat_sop;
  logic               beat_eop;

  logic               out_valid_q, out_sop_q, out_eop_q;
  logic [63:0]        out_data_q;
  logic               skid_valid_q, skid_sop_q, skid_eop_q;
  logic [63:0]        skid_data_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_data[i] = srcData_in[i*64 +: 64];
  end

  // Pick the next owner among sources presenting valid SOP: optional strict
  // priority for source 0, otherwise round-robin starting after the last owner.
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_w;
    // NOTE: every combinational output gets a default before any branch so no
    // path through the block leaves it unassigned (which would infer a latch).
    eligible = srcValid_in & srcSOP_in;
    found    = 1'b0;
    pick     = '0;
    idx      = 0;
    idx_w    = '0;
    if (STRICT_SRC0 && eligible[0]) begin
      found = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        idx = int'(last_q) + k;
        if (idx >= NUM_SRC) idx = idx - NUM_SRC;
        idx_w = IW'(idx);
        if (!found && eligible[idx_w]) begin
          found = 1'b1;
          pick  = idx_w;
        end
      end
    end
  end

  // Next-state, source readies, beat acceptance and framing-error tracking.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    first_d = first_q;
    err_d   = err_q;
    ready   = '0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A mid-packet beat with no owner is swallowed and flagged.
        ready = srcValid_in & ~srcSOP_in;
        err_d = err_q | (srcValid_in & ~srcSOP_in);
        if (found) begin
          state_d = S_LOCKED;
          owner_d = pick;
          last_d  = pick;
          first_d = 1'b1;
        end
      end
      S_LOCKED: begin
        ready[owner_q] = ~skid_valid_q;
        accept         = srcValid_in[owner_q] & ~skid_valid_q;
        if (accept) begin
          first_d = 1'b0;
          if (srcSOP_in[owner_q] && !first_q) err_d[owner_q] = 1'b1;
          if (srcEOP_in[owner_q]) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Nothing is handed over while reset is being applied.
    if (reset_in) begin
      ready  = '0;
      accept = 1'b0;
    end
  end

  assign beat_data = src_data[owner_q];
  assign beat_sop  = srcSOP_in[owner_q];
  assign beat_eop  = srcEOP_in[owner_q];

  // Arbiter state register.
  always_ff @(posedge clk_in) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    if (reset_in) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_SRC - 1);
      first_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  // Skid-stage occupancy and output register: the output moves only when it
  // is empty or being taken; the skid entry always drains first (FIFO order).
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || txReady_in) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        out_sop_q    <= skid_sop_q;
        out_eop_q    <= skid_eop_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= beat_data;
        out_sop_q   <= beat_sop;
        out_eop_q   <= beat_eop;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
    end
  end

  // Skid payload capture when the output register is stalled.
  always_ff @(posedge clk_in) begin
    // NOTE: the skid payload carries no reset; it is only ever read while
    // skid_valid_q (which is reset) says it holds a beat.
    if (accept && out_valid_q && !txReady_in) begin
      skid_data_q <= beat_data;
      skid_sop_q  <= beat_sop;
      skid_eop_q  <= beat_eop;
    end
  end

  // Current owner as one-hot, zero when idle.
  always_comb begin
    grant_out = '0;
    if (state_q == S_LOCKED) grant_out[owner_q] = 1'b1;
  end

  assign srcReady_out = ready;
  assign txValid_out  = out_valid_q;
  assign txSOP_out    = out_sop_q;
  assign txEOP_out    = out_eop_q;
  assign txData_out   = out_data_q;
  assign frameErr_out = err_q;

endmodule
